// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: Moore control sequencer driving register-select and datapath strobes per opcode.
// Optional SEQ_MEM_WAIT_EN: ld T6 / st T7 stall until mem_ready.
module reg_select_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        Yin,
    output logic        Zin,
    output logic        Zout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);
`ifdef SEQ_MEM_WAIT_EN
    localparam logic WAIT = 1'b1;
`else
    localparam logic WAIT = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6, T7} state_t;
    localparam logic [16:0] GRA    = 17'(1) << 16;
    localparam logic [16:0] GRB    = 17'(1) << 15;
    localparam logic [16:0] GRC    = 17'(1) << 14;
    localparam logic [16:0] RIN    = 17'(1) << 13;
    localparam logic [16:0] ROUT   = 17'(1) << 12;
    localparam logic [16:0] BAOUT  = 17'(1) << 11;
    localparam logic [16:0] COUT   = 17'(1) << 10;
    localparam logic [16:0] YIN    = 17'(1) << 9;
    localparam logic [16:0] ZIN    = 17'(1) << 8;
    localparam logic [16:0] ZOUT   = 17'(1) << 7;
    localparam logic [16:0] MARIN  = 17'(1) << 6;
    localparam logic [16:0] MDRIN  = 17'(1) << 5;
    localparam logic [16:0] MDROUT = 17'(1) << 4;
    localparam logic [16:0] READ   = 17'(1) << 3;
    localparam logic [16:0] WRITE  = 17'(1) << 2;
    localparam logic [16:0] DONE   = 17'(1) << 1;
    localparam logic [16:0] ILL    = 17'(1);
    state_t      state, nxt;
    logic [4:0]  nop;
    logic [16:0] strb;
    logic        done_r;
    logic        unused_ir;
    assign unused_ir = ^IR[26:0];
    // opcodes 0..14 are all defined; rf = 3..11, ld = 0, st = 2, others are immediate forms
    function automatic logic [16:0] decode(state_t s, logic [4:0] op);
        logic rf;
        rf = op >= 5'd3 && op <= 5'd11;
        case (s)
            T3:      decode = op > 5'd14 ? ILL : rf ? GRB | ROUT | YIN : GRB | BAOUT | YIN;
            T4:      decode = rf ? GRC | ROUT | ZIN : COUT | ZIN;
            T5:      decode = (op == 5'd0 || op == 5'd2) ? ZOUT | MARIN : ZOUT | GRA | RIN | DONE;
            T6:      decode = op == 5'd0 ? READ | MDRIN : GRA | ROUT | MDRIN;
            T7:      decode = op == 5'd0 ? MDROUT | GRA | RIN | DONE : WRITE | DONE;
            default: decode = '0;
        endcase
    endfunction
    always_comb begin
        nxt = state;
        nop = alu_op;
        case (state)
            IDLE: begin
                nxt = start ? T3 : IDLE;
                nop = start ? IR[31:27] : alu_op;
            end
            T3:      nxt = alu_op <= 5'd14 ? T4 : IDLE;
            T4:      nxt = T5;
            T5:      nxt = (alu_op == 5'd0 || alu_op == 5'd2) ? T6 : IDLE;
            T6:      nxt = (WAIT && alu_op == 5'd0 && !mem_ready) ? T6 : T7;
            T7:      nxt = (WAIT && alu_op == 5'd2 && !mem_ready) ? T7 : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            alu_op <= '0;
            strb   <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= nxt;
            alu_op <= nop;
            strb   <= decode(nxt, nop);
            busy   <= nxt != IDLE;
        end
    end
    assign {Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, Zin, Zout,
            MARin, MDRin, MDRout, Read, Write, done_r, illegal} = strb;
    // a stalled store only reports completion in the cycle memory acknowledges
    assign done = done_r & (mem_ready | !(WAIT && state == T7 && alu_op == 5'd2));
endmodule
